// File: rtl/shape_hit_pipe_pkg.sv
// Shared definitions for the shape hit pipeline: slot shape encoding and
// default sizing constants used by the top level and the per-slot tester.
package shape_hit_pipe_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,  // Chebyshev: |dx| < r and |dy| < r
    MODE_CIRCLE = 1'b1   // Euclidean: dx^2 + dy^2 < r^2
  } shape_mode_e;

  localparam int DEF_W     = 12;
  localparam int DEF_N_OBJ = 4;
  localparam int DEF_IDX_W = $clog2(DEF_N_OBJ);

endpackage

// File: rtl/shape_hit_pipe_shape_test.sv
// shape_test: distance and coverage test for one object slot.
//   Stage 1 registers |obj - draw| per axis together with the slot's radius,
//   mode and enable, so later slot writes cannot disturb a pixel in flight.
//   Stage 2 registers the coverage decision.
// Ports:
//   clk, rst            clock, async active-high reset
//   load                a pixel is accepted this cycle (captures stage 1)
//   obj_x/obj_y/obj_r   slot centre and radius
//   obj_mode, obj_on    slot shape (0 square, 1 circle) and enable
//   draw_x, draw_y      pixel coordinate
//   hit                 stage 2 coverage bit for the pixel in stage 2
module shape_test
  import shape_hit_pipe_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] obj_x,
  input  logic [W-1:0] obj_y,
  input  logic [W-1:0] obj_r,
  input  logic         obj_mode,
  input  logic         obj_on,
  input  logic [W-1:0] draw_x,
  input  logic [W-1:0] draw_y,
  output logic         hit
);

  logic [W:0]     dx_d, dx_q, dy_d, dy_q;
  logic [W-1:0]   r_d, r_q;
  shape_mode_e    mode_d, mode_q;
  logic           on_d, on_q;
  logic           hit_d, hit_q;
  logic [2*W+1:0] ex, ey, er, dist2, rad2;

  // Extended by one bit so the subtraction never wraps at the coordinate edges.
  function automatic logic [W:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] ea, eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

  always_comb begin
    dx_d   = dx_q;
    dy_d   = dy_q;
    r_d    = r_q;
    mode_d = mode_q;
    on_d   = on_q;
    if (load) begin
      dx_d   = abs_diff(obj_x, draw_x);
      dy_d   = abs_diff(obj_y, draw_y);
      r_d    = obj_r;
      mode_d = shape_mode_e'(obj_mode);
      on_d   = obj_on;
    end
  end

  // Squares are formed at full width so neither side of the circle compare
  // is ever truncated.
  always_comb begin
    ex    = {{(W+1){1'b0}}, dx_q};
    ey    = {{(W+1){1'b0}}, dy_q};
    er    = {{(W+2){1'b0}}, r_q};
    dist2 = ex * ex + ey * ey;
    rad2  = er * er;
    hit_d = 1'b0;
    if (on_q && (r_q != '0)) begin
      if (mode_q == MODE_CIRCLE) begin
        hit_d = (dist2 < rad2);
      end else begin
        hit_d = ({1'b0, r_q} > dx_q) && ({1'b0, r_q} > dy_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx_q   <= '0;
      dy_q   <= '0;
      r_q    <= '0;
      mode_q <= MODE_SQUARE;
      on_q   <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      dx_q   <= dx_d;
      dy_q   <= dy_d;
      r_q    <= r_d;
      mode_q <= mode_d;
      on_q   <= on_d;
      hit_q  <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/shape_hit_pipe.sv
// shape_hit_pipe: three-stage pixel-versus-object coverage pipeline.
//   N_OBJ loadable slots (square or circle). Every accepted pixel produces a
//   result exactly three cycles later: S1 distances, S2 per-slot hits,
//   S3 priority-encoded outputs. A sticky collision flag records any result
//   covered by two or more slots; frame_start clears it without flushing.
// Ports:
//   clk, rst                  clock, async active-high reset
//   wr_en, wr_idx             slot write strobe and index (out of range ignored)
//   wr_x, wr_y, wr_r          slot centre and radius
//   wr_mode, wr_on            slot shape (0 square, 1 circle) and enable
//   pix_valid, x_draw, y_draw pixel input
//   frame_start               frame boundary pulse
//   out_valid, hit, hit_idx, hit_mask   result (all zero when not valid)
//   collision                 sticky multi-cover flag for the current frame
module shape_hit_pipe
  import shape_hit_pipe_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N_OBJ = DEF_N_OBJ,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_x,
  input  logic [W-1:0]     wr_y,
  input  logic [W-1:0]     wr_r,
  input  logic             wr_mode,
  input  logic             wr_on,
  input  logic             pix_valid,
  input  logic [W-1:0]     x_draw,
  input  logic [W-1:0]     y_draw,
  input  logic             frame_start,
  output logic             out_valid,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic [N_OBJ-1:0] hit_mask,
  output logic             collision
);

  logic [W-1:0]     slot_x_d [N_OBJ];
  logic [W-1:0]     slot_x_q [N_OBJ];
  logic [W-1:0]     slot_y_d [N_OBJ];
  logic [W-1:0]     slot_y_q [N_OBJ];
  logic [W-1:0]     slot_r_d [N_OBJ];
  logic [W-1:0]     slot_r_q [N_OBJ];
  logic [N_OBJ-1:0] slot_mode_d, slot_mode_q;
  logic [N_OBJ-1:0] slot_on_d, slot_on_q;

  logic             v1_d, v1_q, v2_d, v2_q;
  logic [N_OBJ-1:0] hit_vec;

  logic             out_valid_d, out_valid_q;
  logic             hit_d, hit_q;
  logic [IDX_W-1:0] hit_idx_d, hit_idx_q;
  logic [N_OBJ-1:0] hit_mask_d, hit_mask_q;
  logic             collision_d, collision_q;
  logic             seen, multi;

  // Decoding against each legal index drops writes to indices >= N_OBJ.
  always_comb begin
    slot_x_d    = slot_x_q;
    slot_y_d    = slot_y_q;
    slot_r_d    = slot_r_q;
    slot_mode_d = slot_mode_q;
    slot_on_d   = slot_on_q;
    for (int i = 0; i < N_OBJ; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        slot_x_d[i]    = wr_x;
        slot_y_d[i]    = wr_y;
        slot_r_d[i]    = wr_r;
        slot_mode_d[i] = wr_mode;
        slot_on_d[i]   = wr_on;
      end
    end
  end

  // Slot registers feed S1 directly, so a write on the same edge as a pixel
  // is seen only by later pixels.
  for (genvar g = 0; g < N_OBJ; g++) begin : g_slot
    shape_test #(.W(W)) u_shape_test (
      .clk      (clk),
      .rst      (rst),
      .load     (pix_valid),
      .obj_x    (slot_x_q[g]),
      .obj_y    (slot_y_q[g]),
      .obj_r    (slot_r_q[g]),
      .obj_mode (slot_mode_q[g]),
      .obj_on   (slot_on_q[g]),
      .draw_x   (x_draw),
      .draw_y   (y_draw),
      .hit      (hit_vec[g])
    );
  end

  always_comb begin
    v1_d        = pix_valid;
    v2_d        = v1_q;
    out_valid_d = v2_q;
    hit_mask_d  = v2_q ? hit_vec : '0;
    hit_d       = |hit_mask_d;
    hit_idx_d   = '0;
    // Descending scan leaves the lowest covering slot in hit_idx_d.
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit_mask_d[i]) hit_idx_d = IDX_W'(i);
    end
  end

  // Two or more covering slots on the presented result sets the flag; the set
  // takes priority over a coincident frame_start clear.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (hit_mask_q[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    collision_d = collision_q;
    if (frame_start) collision_d = 1'b0;
    if (out_valid_q && multi) collision_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_OBJ; i++) begin
        slot_x_q[i] <= '0;
        slot_y_q[i] <= '0;
        slot_r_q[i] <= '0;
      end
      slot_mode_q <= '0;
      slot_on_q   <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      hit_mask_q  <= '0;
      collision_q <= 1'b0;
    end else begin
      slot_x_q    <= slot_x_d;
      slot_y_q    <= slot_y_d;
      slot_r_q    <= slot_r_d;
      slot_mode_q <= slot_mode_d;
      slot_on_q   <= slot_on_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      hit_mask_q  <= hit_mask_d;
      collision_q <= collision_d;
    end
  end

  assign out_valid = out_valid_q;
  assign hit       = hit_q;
  assign hit_idx   = hit_idx_q;
  assign hit_mask  = hit_mask_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_shape_hit_pipe.sv
module tb_shape_hit_pipe;

  localparam int W     = 12;
  localparam int N_OBJ = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [W-1:0]     wr_x, wr_y, wr_r;
  logic             wr_mode, wr_on;
  logic             pix_valid;
  logic [W-1:0]     x_draw, y_draw;
  logic             frame_start;
  logic             out_valid, hit, collision;
  logic [IDX_W-1:0] hit_idx;
  logic [N_OBJ-1:0] hit_mask;

  shape_hit_pipe #(.W(W), .N_OBJ(N_OBJ), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_r        (wr_r),
    .wr_mode     (wr_mode),
    .wr_on       (wr_on),
    .pix_valid   (pix_valid),
    .x_draw      (x_draw),
    .y_draw      (y_draw),
    .frame_start (frame_start),
    .out_valid   (out_valid),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .hit_mask    (hit_mask),
    .collision   (collision)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic [N_OBJ-1:0] mask;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference slot table, plain integers.
  int m_x[N_OBJ], m_y[N_OBJ], m_r[N_OBJ];
  bit m_circle[N_OBJ], m_on[N_OBJ];
  bit coll_exp;
  bit mon_multi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [N_OBJ-1:0] model_mask(input int px, input int py);
    logic [N_OBJ-1:0] m;
    int dx, dy;
    m = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      dx = (m_x[i] > px) ? m_x[i] - px : px - m_x[i];
      dy = (m_y[i] > py) ? m_y[i] - py : py - m_y[i];
      if (m_on[i] && m_r[i] > 0) begin
        if (m_circle[i]) m[i] = (dx * dx + dy * dy) < (m_r[i] * m_r[i]);
        else             m[i] = (dx < m_r[i]) && (dy < m_r[i]);
      end
    end
    return m;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N_OBJ; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_r[i] = 0; m_circle[i] = 0; m_on[i] = 0;
    end
  endtask

  task automatic set_write(input int idx, input int x, input int y, input int r,
                           input bit circ, input bit on);
    wr_en   = 1'b1;
    wr_idx  = IDX_W'(idx);
    wr_x    = W'(x);
    wr_y    = W'(y);
    wr_r    = W'(r);
    wr_mode = circ;
    wr_on   = on;
  endtask

  task automatic set_pix(input int px, input int py);
    pix_valid = 1'b1;
    x_draw    = W'(px);
    y_draw    = W'(py);
  endtask

  // Predict for the pixel (using the table before this cycle's write), then
  // apply the write, then clock.
  task automatic tick();
    exp_t e;
    int   wi;
    if (pix_valid && !rst) begin
      e.mask = model_mask(int'(x_draw), int'(y_draw));
      e.hit  = |e.mask;
      e.idx  = '0;
      for (int i = N_OBJ - 1; i >= 0; i--) if (e.mask[i]) e.idx = IDX_W'(i);
      e.cyc  = cyc + 3;
      exp_q.push_back(e);
    end
    if (wr_en && !rst) begin
      wi = int'(wr_idx);
      if (wi < N_OBJ) begin
        m_x[wi] = int'(wr_x); m_y[wi] = int'(wr_y); m_r[wi] = int'(wr_r);
        m_circle[wi] = wr_mode; m_on[wi] = wr_on;
      end
    end
    @(posedge clk);
    #1;
    wr_en       = 1'b0;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    exp_q.delete();
    clear_model();
    coll_exp = 1'b0;
    set_pix(10, 10);  // presented during reset, must be ignored
    repeat (n) @(posedge clk);
    #1;
    rst       = 1'b0;
    pix_valid = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs", 32'({out_valid, hit, hit_idx, hit_mask, collision}), 32'd0);
      coll_exp = 1'b0;
    end else begin
      mon_multi = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("latency",  32'(cyc), 32'(mon_e.cyc));
          check("hit",      32'(hit), 32'(mon_e.hit));
          check("hit_idx",  32'(hit_idx), 32'(mon_e.idx));
          check("hit_mask", 32'(hit_mask), 32'(mon_e.mask));
          mon_multi = ($countones(mon_e.mask) >= 2);
        end
      end else begin
        check("idle_zero", 32'({hit, hit_idx, hit_mask}), 32'd0);
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          check("out_valid", 32'(out_valid), 32'd1);
          void'(exp_q.pop_front());
        end
      end
      check("collision", 32'(collision), 32'(coll_exp));
      if (mon_multi)        coll_exp = 1'b1;
      else if (frame_start) coll_exp = 1'b0;
    end
  end

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_write($urandom_range(0, N_OBJ - 1),
                  ($urandom_range(0, 15) == 0) ? 4095 : $urandom_range(0, 63),
                  ($urandom_range(0, 15) == 0) ? 4095 : $urandom_range(0, 63),
                  ($urandom_range(0, 15) == 0) ? 4095 : $urandom_range(0, 24),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
      end
      if ($urandom_range(0, 3) != 0) begin
        set_pix(($urandom_range(0, 20) == 0) ? 4095 : $urandom_range(0, 63),
                ($urandom_range(0, 20) == 0) ? 0    : $urandom_range(0, 63));
      end
      if ($urandom_range(0, 15) == 0) frame_start = 1'b1;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_r = '0;
    wr_mode = 1'b0; wr_on = 1'b0; pix_valid = 1'b0; x_draw = '0; y_draw = '0;
    frame_start = 1'b0;
    clear_model();
    coll_exp = 1'b0;
    do_reset(3);

    // Square slot 0 at (100,100) r=10: x=90..110 on y=100.
    set_write(0, 100, 100, 10, 1'b0, 1'b1); tick();
    for (int x = 90; x <= 110; x++) begin set_pix(x, 100); tick(); end
    idle(4);

    // Circle slot 1 at (200,200) r=5: dist^2 25 misses, 18 hits.
    set_write(1, 200, 200, 5, 1'b1, 1'b1); tick();
    set_pix(203, 204); tick();
    set_pix(203, 203); tick();
    idle(4);

    // Overlap of slots 0 and 2 at (50,50), then frame_start clears collision.
    set_write(0, 50, 50, 3, 1'b0, 1'b1); tick();
    set_write(2, 52, 52, 5, 1'b1, 1'b1); tick();
    set_pix(50, 50); tick();
    idle(4);
    frame_start = 1'b1; tick();
    idle(3);

    // Coordinate extremes, no wrap-around.
    set_write(0, 0, 0, 4095, 1'b0, 1'b1); tick();
    set_pix(4094, 0); tick();
    set_write(0, 0, 0, 0, 1'b0, 1'b0);
    set_write(1, 4095, 4095, 1, 1'b0, 1'b1); tick();
    tick();
    set_write(1, 4095, 4095, 1, 1'b0, 1'b1); tick();
    set_pix(0, 0); tick();
    set_pix(4095, 4095); tick();
    idle(4);

    // Write while a pixel is in flight.
    set_write(0, 10, 10, 5, 1'b0, 1'b1); tick();
    set_pix(10, 10); tick();
    set_write(0, 10, 10, 5, 1'b0, 1'b0); tick();
    set_pix(10, 10); tick();
    set_pix(11, 9); tick();
    idle(4);

    // Reset with two pixels in flight.
    set_write(3, 20, 20, 8, 1'b1, 1'b1); tick();
    set_pix(20, 20); tick();
    set_pix(21, 21); tick();
    do_reset(2);
    set_write(3, 20, 20, 8, 1'b1, 1'b1); tick();
    set_pix(20, 20); tick();
    idle(4);

    random_phase(400);
    set_pix(5, 5); tick();
    set_pix(6, 6); tick();
    do_reset(2);
    random_phase(400);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
